// File: rtl/perf_stats_collector.sv
// Run-statistics stage ahead of perf_counter: counts cycles, taken branches and memory writes
// until the PC reaches FINAL_PC, and continuously converts a selected counter to packed BCD.
module perf_stats_collector #(
  parameter logic [15:0] FINAL_PC         = 16'd400,
  parameter int unsigned CNT_WIDTH        = 24,
  parameter int unsigned NUMBER_OF_DIGITS = 8
) (
  input  logic                          CLK_50,
  input  logic                          resetN,
  input  logic [15:0]                   pc,
  input  logic                          write_m,
  input  logic [1:0]                    sel,
  output logic [CNT_WIDTH-1:0]          cycle_count,
  output logic [CNT_WIDTH-1:0]          jump_count,
  output logic [CNT_WIDTH-1:0]          write_count,
  output logic [4*NUMBER_OF_DIGITS-1:0] bcd,
  output logic                          bcd_valid,
  output logic                          finished
);

  localparam int unsigned BW = 4 * NUMBER_OF_DIGITS;
  localparam int unsigned IW = $clog2(CNT_WIDTH + 1);
  localparam logic [IW-1:0]        LAST_ITER = IW'(CNT_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic {RUN, DONE} run_state_t;
  typedef enum logic [1:0] {C_IDLE, C_SHIFT, C_LOAD} conv_state_t;

  run_state_t  run_state, run_next;
  conv_state_t conv_state, conv_next;

  logic                 count_en;
  logic                 is_jump;
  logic [15:0]          prev_pc;
  logic                 prev_valid;
  logic [CNT_WIDTH-1:0] sel_value;
  logic [CNT_WIDTH-1:0] snapshot;
  logic [BW-1:0]        scratch;
  logic [BW-1:0]        scratch_adj;
  logic [IW-1:0]        iter;

  // ---------------- run FSM ----------------
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) run_state <= RUN;
    else         run_state <= run_next;
  end

  always_comb begin
    run_next = run_state;
    if (run_state == RUN && pc == FINAL_PC) run_next = DONE;
  end

  always_comb begin
    count_en = (run_state == RUN);
    finished = (run_state == DONE);
  end

  // prev_pc + 1 stays 16 bits wide so FFFF -> 0000 counts as sequential
  assign is_jump = prev_valid && (pc != prev_pc) && (pc != prev_pc + 16'd1);

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      cycle_count <= '0;
      jump_count  <= '0;
      write_count <= '0;
      prev_pc     <= '0;
      prev_valid  <= 1'b0;
    end else if (count_en) begin
      if (cycle_count != '1)            cycle_count <= cycle_count + CNT_ONE;
      if (write_m && write_count != '1) write_count <= write_count + CNT_ONE;
      if (is_jump && jump_count != '1)  jump_count  <= jump_count + CNT_ONE;
      prev_pc    <= pc;
      prev_valid <= 1'b1;
    end
  end

  // ---------------- BCD converter ----------------
  always_comb begin
    case (sel)
      2'd1:    sel_value = jump_count;
      2'd2:    sel_value = write_count;
      default: sel_value = cycle_count;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) conv_state <= C_IDLE;
    else         conv_state <= conv_next;
  end

  always_comb begin
    conv_next = conv_state;
    case (conv_state)
      C_IDLE:  conv_next = C_SHIFT;
      C_SHIFT: if (iter == LAST_ITER) conv_next = C_LOAD;
      C_LOAD:  conv_next = C_IDLE;
      default: conv_next = C_IDLE;
    endcase
  end

  always_comb begin
    scratch_adj = scratch;
    for (int unsigned d = 0; d < NUMBER_OF_DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      snapshot  <= '0;
      scratch   <= '0;
      iter      <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      case (conv_state)
        C_IDLE: begin
          snapshot <= sel_value;
          scratch  <= '0;
          iter     <= '0;
        end
        C_SHIFT: begin
          {scratch, snapshot} <= {scratch_adj[BW-2:0], snapshot, 1'b0};
          iter                <= iter + 1'b1;
        end
        C_LOAD: begin
          bcd       <= scratch;
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_stats_collector.sv
// Directed bench for perf_stats_collector: default instance plus a narrow-counter instance
// used to reach saturation in a short run.
module tb_perf_stats_collector;

  logic        CLK_50 = 1'b0;
  logic        resetN;
  logic [15:0] pc, pc_s;
  logic        write_m, write_s;
  logic [1:0]  sel, sel_s;
  logic [23:0] cycle_count, jump_count, write_count;
  logic [31:0] bcd;
  logic        bcd_valid, finished;
  logic [3:0]  cyc_s, jmp_s, wr_s;
  logic [7:0]  bcd_s;
  logic        valid_s, fin_s;

  int checks = 0;
  int passed = 0;
  int edges  = 0;

  always #10 CLK_50 = ~CLK_50;

  perf_stats_collector dut (
    .CLK_50(CLK_50), .resetN(resetN), .pc(pc), .write_m(write_m), .sel(sel),
    .cycle_count(cycle_count), .jump_count(jump_count), .write_count(write_count),
    .bcd(bcd), .bcd_valid(bcd_valid), .finished(finished)
  );

  perf_stats_collector #(.FINAL_PC(16'd400), .CNT_WIDTH(4), .NUMBER_OF_DIGITS(2)) dut_s (
    .CLK_50(CLK_50), .resetN(resetN), .pc(pc_s), .write_m(write_s), .sel(sel_s),
    .cycle_count(cyc_s), .jump_count(jmp_s), .write_count(wr_s),
    .bcd(bcd_s), .bcd_valid(valid_s), .finished(fin_s)
  );

  task automatic step();
    @(posedge CLK_50);
    #1;
    edges++;
  endtask

  // conversion LOAD lands on edges%26==0 counted from reset release
  task automatic step_to_phase(input int p);
    for (int i = 0; i < 26; i++) begin
      step();
      if (edges % 26 == p) break;
    end
  endtask

  task automatic release_reset();
    @(posedge CLK_50);
    #1;
    resetN = 1'b1;
    edges  = 0;
  endtask

  task automatic test_reset();
    resetN = 1'b0; pc = 16'd0; write_m = 1'b0; sel = 2'd0;
    pc_s = 16'd0; write_s = 1'b0; sel_s = 2'd1;
    #25;
    checks++; if (cycle_count !== 24'd0) $display("FAIL reset_cycle: got %0d want 0", cycle_count); else passed++;
    checks++; if (jump_count !== 24'd0) $display("FAIL reset_jump: got %0d want 0", jump_count); else passed++;
    checks++; if (write_count !== 24'd0) $display("FAIL reset_write: got %0d want 0", write_count); else passed++;
    checks++; if (bcd !== 32'h0 || bcd_valid !== 1'b0) $display("FAIL reset_bcd: got %h/%b want 0/0", bcd, bcd_valid); else passed++;
    checks++; if (finished !== 1'b0) $display("FAIL reset_finished: got %b want 0", finished); else passed++;
    release_reset();
  endtask

  task automatic test_run_to_final();
    for (int i = 0; i <= 400; i++) begin
      pc = 16'(i);
      step();
      if (i == 399) begin
        checks++;
        if (finished !== 1'b0 || cycle_count !== 24'd400)
          $display("FAIL pre_final: got fin=%b cyc=%0d want fin=0 cyc=400", finished, cycle_count);
        else passed++;
      end
    end
    checks++; if (cycle_count !== 24'd401) $display("FAIL final_cycle: got %0d want 401", cycle_count); else passed++;
    checks++; if (jump_count !== 24'd0 || write_count !== 24'd0)
      $display("FAIL final_jw: got j=%0d w=%0d want 0/0", jump_count, write_count); else passed++;
    checks++; if (finished !== 1'b1) $display("FAIL final_finished: got %b want 1", finished); else passed++;
    for (int i = 0; i < 50; i++) begin
      pc = 16'(1000 + 7 * i);
      write_m = 1'b1;
      step();
    end
    write_m = 1'b0;
    checks++; if (cycle_count !== 24'd401 || jump_count !== 24'd0 || write_count !== 24'd0 || finished !== 1'b1)
      $display("FAIL frozen: got c=%0d j=%0d w=%0d f=%b want 401/0/0/1", cycle_count, jump_count, write_count, finished);
    else passed++;
  endtask

  task automatic test_bcd_select();
    bit found = 1'b0;
    for (int i = 0; i < 52; i++) begin
      if (bcd_valid === 1'b1 && bcd === 32'h00000401) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) $display("FAIL bcd_401: got %h valid=%b want 00000401 valid=1", bcd, bcd_valid); else passed++;
    step_to_phase(10);
    sel = 2'd1;
    step_to_phase(0);
    checks++; if (bcd !== 32'h00000401) $display("FAIL sel_mid_conv: got %h want 00000401", bcd); else passed++;
    step_to_phase(0);
    checks++; if (bcd !== 32'h00000000) $display("FAIL sel_next_conv: got %h want 00000000", bcd); else passed++;
  endtask

  task automatic test_reset_mid_shift();
    int n = 0;
    step_to_phase(10);
    #5;
    pc = 16'd9;
    resetN = 1'b0;
    #1;
    checks++; if (bcd !== 32'h0 || bcd_valid !== 1'b0 || finished !== 1'b0 || cycle_count !== 24'd0)
      $display("FAIL async_reset: got bcd=%h v=%b f=%b c=%0d want 0/0/0/0", bcd, bcd_valid, finished, cycle_count);
    else passed++;
    sel = 2'd0;
    release_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (bcd_valid === 1'b1) break;
    end
    checks++; if (n != 26 || bcd_valid !== 1'b1) $display("FAIL first_valid: got %0d cycles want 26", n); else passed++;
  endtask

  task automatic test_jumps_writes();
    logic [15:0] seq [7];
    logic        wm  [7];
    bit          found = 1'b0;
    seq = '{16'd10, 16'd11, 16'd11, 16'd50, 16'd51, 16'd5, 16'd6};
    wm  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      pc = seq[i];
      write_m = wm[i];
      step();
    end
    write_m = 1'b0;
    checks++; if (jump_count !== 24'd2) $display("FAIL jumps: got %0d want 2", jump_count); else passed++;
    checks++; if (write_count !== 24'd3) $display("FAIL writes: got %0d want 3", write_count); else passed++;
    for (int i = 0; i < 5; i++) step();
    checks++; if (jump_count !== 24'd2 || write_count !== 24'd3)
      $display("FAIL hold_pc: got j=%0d w=%0d want 2/3", jump_count, write_count); else passed++;
    sel = 2'd1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bcd === 32'h00000002) begin found = 1'b1; break; end
    end
    checks++; if (!found) $display("FAIL bcd_jumps: got %h want 00000002", bcd); else passed++;
    step_to_phase(10);
    sel = 2'd2;
    step_to_phase(0);
    checks++; if (bcd !== 32'h00000002) $display("FAIL sel2_mid_conv: got %h want 00000002", bcd); else passed++;
    step_to_phase(0);
    checks++; if (bcd !== 32'h00000003) $display("FAIL sel2_next_conv: got %h want 00000003", bcd); else passed++;
  endtask

  task automatic test_wrap();
    logic [15:0] seq [5];
    seq = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    #3;
    pc = 16'hFFFD;
    resetN = 1'b0;
    release_reset();
    for (int i = 0; i < 5; i++) begin
      pc = seq[i];
      step();
    end
    checks++; if (jump_count !== 24'd0 || cycle_count !== 24'd5)
      $display("FAIL wrap: got j=%0d c=%0d want 0/5", jump_count, cycle_count); else passed++;
    pc = 16'd3;
    step();
    checks++; if (jump_count !== 24'd1) $display("FAIL skip_jump: got %0d want 1", jump_count); else passed++;
  endtask

  task automatic test_saturation();
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) step();
    checks++; if (cyc_s !== 4'd15 || jmp_s !== 4'd0 || wr_s !== 4'd0)
      $display("FAIL sat_idle: got c=%0d j=%0d w=%0d want 15/0/0", cyc_s, jmp_s, wr_s); else passed++;
    write_s = 1'b1;
    for (int k = 0; k < 14; k++) begin
      pc_s = (k % 2 == 0) ? 16'd100 : 16'd0;
      step();
    end
    checks++; if (jmp_s !== 4'd14 || wr_s !== 4'd14)
      $display("FAIL sat_minus1: got j=%0d w=%0d want 14/14", jmp_s, wr_s); else passed++;
    for (int k = 14; k < 19; k++) begin
      pc_s = (k % 2 == 0) ? 16'd100 : 16'd0;
      step();
    end
    write_s = 1'b0;
    checks++; if (jmp_s !== 4'd15 || wr_s !== 4'd15 || cyc_s !== 4'd15)
      $display("FAIL sat_hold: got j=%0d w=%0d c=%0d want 15/15/15", jmp_s, wr_s, cyc_s); else passed++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid_s === 1'b1 && bcd_s === 8'h15) begin found = 1'b1; break; end
    end
    checks++; if (!found) $display("FAIL sat_bcd: got %h want 15", bcd_s); else passed++;
  endtask

  initial begin
    test_reset();
    test_run_to_final();
    test_bcd_select();
    test_reset_mid_shift();
    test_jumps_writes();
    test_wrap();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
